// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A destination register is usable as a hazard source only when written and not r0.
  function automatic logic dest_hit(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of pipe-register fields in and pipeline control out of the hazard unit.
// Latency: n/a (wires only).
// Backpressure: n/a; the slave side drives enables that stall the pipeline.
interface hazard_control_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 id_jump;
  logic [4:0]           ex_rs;
  logic [4:0]           ex_rt;
  logic [4:0]           ex_rd;
  logic                 ex_regwrite;
  logic                 ex_memread;
  logic [4:0]           mem_rd;
  logic                 mem_regwrite;
  logic                 mem_branch_taken;
  logic [4:0]           wb_rd;
  logic                 wb_regwrite;
  logic                 pc_enable;
  logic                 if_id_enable;
  logic                 if_id_flush;
  logic                 id_exe_flush;
  logic                 exe_mem_flush;
  logic [1:0]           forward_a;
  logic [1:0]           forward_b;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Pipeline side: supplies register fields, consumes control.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_branch_taken, wb_rd, wb_regwrite,
    input  pc_enable, if_id_enable, if_id_flush, id_exe_flush, exe_mem_flush,
           forward_a, forward_b, stall_count, flush_count
  );

  // Hazard unit side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_branch_taken, wb_rd, wb_regwrite,
    output pc_enable, if_id_enable, if_id_flush, id_exe_flush, exe_mem_flush,
           forward_a, forward_b, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit_fwd.sv
// ALU operand forwarding select: MEM result beats WB result, r0 never forwarded.
// Latency: combinational, zero cycles.
// Backpressure: none.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_regwrite_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
);

  // Newest producer (MEM) takes priority over the older one (WB).
  always_comb begin
    forward_a_o = FWD_REG;
    forward_b_o = FWD_REG;
    if (dest_hit(mem_regwrite_i, mem_rd_i, ex_rs_i))     forward_a_o = FWD_MEM;
    else if (dest_hit(wb_regwrite_i, wb_rd_i, ex_rs_i))  forward_a_o = FWD_WB;
    if (dest_hit(mem_regwrite_i, mem_rd_i, ex_rt_i))     forward_b_o = FWD_MEM;
    else if (dest_hit(wb_regwrite_i, wb_rd_i, ex_rt_i))  forward_b_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// 5-stage MIPS hazard controller: load-use bubbles, branch/jump squash, forwarding, perf counters.
// Latency: control outputs combinational; state and counters update on the rising edge.
// Backpressure: drops pc_enable/if_id_enable for LOAD_STALL_CYCLES per load-use; counters built only with HAZARD_PERF_COUNTERS_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_control_unit_if.slave hif
);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic       pc_en, ifid_en, ifid_fl, idexe_fl, exmem_fl;
  logic [1:0] fwd_a, fwd_b;

  // Load in EXE whose destination is read by the instruction in ID.
  always_comb begin
    load_use = hif.ex_memread && hif.ex_regwrite && (hif.ex_rd != REG_ZERO) &&
               ((hif.id_uses_rs && (hif.id_rs == hif.ex_rd)) ||
                (hif.id_uses_rt && (hif.id_rt == hif.ex_rd)));
  end

  // Next state and control outputs; taken branch dominates, then stall, then jump.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_fl   = 1'b0;
    idexe_fl  = 1'b0;
    exmem_fl  = 1'b0;
    if (!reset) begin
      if (hif.mem_branch_taken) begin
        ifid_fl   = 1'b1;
        idexe_fl  = 1'b1;
        exmem_fl  = 1'b1;
        state_d   = RUN;
        cnt_d     = 3'd0;
        flush_inc = 1'b1;
      end else if (state_q == STALL) begin
        // Bubble continues regardless of what ID/EXE show now.
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idexe_fl  = 1'b1;
        stall_inc = 1'b1;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end else if (load_use) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idexe_fl  = 1'b1;
        stall_inc = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = STALL;
          cnt_d   = 3'(LOAD_STALL_CYCLES - 1);
        end
      end else if (hif.id_jump) begin
        ifid_fl   = 1'b1;
        flush_inc = 1'b1;
      end
    end
  end

  // FSM state and remaining-bubble counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  forwarding_unit u_fwd (
    .ex_rs_i        (hif.ex_rs),
    .ex_rt_i        (hif.ex_rt),
    .mem_rd_i       (hif.mem_rd),
    .mem_regwrite_i (hif.mem_regwrite),
    .wb_rd_i        (hif.wb_rd),
    .wb_regwrite_i  (hif.wb_regwrite),
    .forward_a_o    (fwd_a),
    .forward_b_o    (fwd_b)
  );

  assign hif.pc_enable     = pc_en;
  assign hif.if_id_enable  = ifid_en;
  assign hif.if_id_flush   = ifid_fl;
  assign hif.id_exe_flush  = idexe_fl;
  assign hif.exe_mem_flush = exmem_fl;
  assign hif.forward_a     = reset ? FWD_REG : fwd_a;
  assign hif.forward_b     = reset ? FWD_REG : fwd_b;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; they stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_count = stall_cnt_q;
  assign hif.flush_count = flush_cnt_q;
`else
  logic unused_cnt_inc;
  assign unused_cnt_inc  = stall_inc ^ flush_inc;
  assign hif.stall_count = '0;
  assign hif.flush_count = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central pipeline controller for the 5-stage MIPS core (IF/ID, ID/EXE, EXE/MEM, MEM/WB registers).
- Sequences the pipeline by driving PC and IF/ID enables and per-register flushes.
- Inserts load-use bubbles with a small FSM and squashes wrong-path instructions on taken branches and jumps.
- Generates ALU operand forwarding selects. Sits beside the Control unit; consumes register numbers and control bits from the pipe registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  j/jal/jr decoded in ID
- ex_rs  in  5  rs of the instruction in EXE
- ex_rt  in  5  rt of the instruction in EXE
- ex_rd  in  5  destination register selected in EXE
- ex_regwrite  in  1  EXE instruction writes a register
- ex_memread  in  1  EXE instruction is a load
- mem_rd  in  5  destination register in MEM
- mem_regwrite  in  1  MEM instruction writes a register
- mem_branch_taken  in  1  branch resolved taken in MEM
- wb_rd  in  5  destination register in WB
- wb_regwrite  in  1  WB instruction writes a register
- pc_enable  out  1  PC register load enable
- if_id_enable  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register clears to NOP
- id_exe_flush  out  1  ID/EXE register clears control bits
- exe_mem_flush  out  1  EXE/MEM register clears control bits
- forward_a  out  2  ALU A source select
- forward_b  out  2  ALU B source select
- stall_count  out  CNT_WIDTH  bubbles inserted since reset
- flush_count  out  CNT_WIDTH  taken-branch and jump flush events since reset

Behaviour:
- Reset: state=RUN, bubble counter=0, stall_count=0, flush_count=0.
- Outputs during reset: pc_enable=1, if_id_enable=1, all flushes=0, forward_a=forward_b=00.
- FSM states: RUN, STALL. Register 0 never causes a hazard and is never forwarded.
- load_use = ex_memread & ex_regwrite & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority 1, mem_branch_taken, any state:
  - pc_enable=1, if_id_enable=1.
  - if_id_flush=1, id_exe_flush=1, exe_mem_flush=1.
  - Next state RUN, bubble counter cleared, flush_count+1.
  - A concurrent load_use or id_jump is ignored.
- Priority 2, RUN & load_use:
  - pc_enable=0, if_id_enable=0, id_exe_flush=1, stall_count+1.
  - If LOAD_STALL_CYCLES>1: next state STALL, counter=LOAD_STALL_CYCLES-1. Otherwise stay in RUN.
- STALL, no branch:
  - Same outputs as the load_use cycle, stall_count+1, counter decrements.
  - When counter==1, next state RUN.
  - load_use is not re-evaluated in STALL.
- Priority 3, RUN & id_jump & !load_use: if_id_flush=1, pc_enable=1, flush_count+1. A jump held by a stall is flushed on the first RUN cycle after the stall.
- Otherwise all enables are 1 and all flushes are 0.
- Control outputs are combinational from state and inputs. State, counter and perf counters update on the rising edge only.
- forward_a (combinational), first match wins:
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs
  - 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs
  - else 00
  - 11 is never driven.
- forward_b: same rules using ex_rt.
- Perf counters saturate at all-ones; they do not wrap.
- Reset asserted mid-STALL returns to RUN immediately, asynchronously.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined: stall_count and flush_count implemented as above.
- Undefined: no counter flops are built; both outputs are tied to 0.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state encoding (RUN=1'b0, STALL=1'b1)
  - forwarding select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_ZERO=5'd0
- One natural combinational sub-module, forwarding_unit: computes forward_a and forward_b from ex_rs, ex_rt and the MEM/WB destinations.

Test Plan:
- Reset, then idle inputs -> pc_enable=1, if_id_enable=1, flushes=0, forward selects 00, counters 0.
- ex_memread=1, ex_regwrite=1, ex_rd=8, id_rs=8, id_uses_rs=1, LOAD_STALL_CYCLES=3 -> exactly 3 cycles of pc_enable=0 and id_exe_flush=1, then RUN; stall_count=3.
- Branch on the 2nd stall cycle (LOAD_STALL_CYCLES=3) -> that cycle all three flushes=1 and pc_enable=1; next cycle RUN with no further stall; flush_count=1.
- mem_rd=5 and wb_rd=5, both regwrite, ex_rs=5 -> forward_a=10. mem_rd=0 and wb_rd=0, ex_rt=0 -> forward_b=00.
- id_jump=1 during load_use -> held for 1 cycle with no if_id_flush; next cycle if_id_flush=1.
- Force stall_count to all-ones and continue stalling -> value holds. Build without HAZARD_PERF_COUNTERS_EN -> both counters constantly 0.
